tsfm_bus_seq: RTL and testbench
===============================

// Module: tsfm_bus_seq
// PURPOSE
//  Bus-cycle sequencer between the Z80 port decoder and the two YM2203 (TurboSound FM) chips.
//  Converts a decoded Z80 I/O access into a timed chip cycle: setup, strobe, hold.
//  Enforces per-chip write-recovery time and holds the CPU via n_wait while a chip is not ready.
//  Latches read data so the CPU sees stable data after the strobe ends.
// PARAMETERS
//  SETUP_CYC   1   clkcpu cycles from CS/A0 valid to strobe assert (1..3)
//  STROBE_CYC  3   clkcpu cycles n_ard/n_awr held low (1..7)
//  HOLD_CYC    1   clkcpu cycles CS/A0/data held after strobe release (1..3)
//  ADDR_RECOV  2   recovery cycles after an address write (a0=0), per chip (0..31)
//  DATA_RECOV  17  recovery cycles after a data write (a0=1), per chip (0..31)
// PORTS
//  clkcpu      in   1  Z80 clock
//  rst_n       in   1  Reset, asynchronous, active-low
//  io_req      in   1  Decoded FM access active (port hit & ~n_iorq & n_m1); level, held by CPU
//  io_wr       in   1  1=write, 0=read; valid while io_req
//  io_a0       in   1  Chip A0 for this access
//  chip_sel    in   1  0=chip 1, 1=chip 2; sampled on io_req rise
//  d_in        in   8  CPU write data
//  d_out       out  8  Latched read data to CPU bus
//  d_out_en    out  1  Drive d_out onto CPU bus
//  ad_in       in   8  Chip data bus input
//  ad_out      out  8  Chip data bus output
//  ad_oe       out  1  Drive ad_out onto chip bus
//  aa0         out  1  Chip A0
//  n_ard       out  1  Chip read strobe, active-low
//  n_awr       out  1  Chip write strobe, active-low
//  n_ym_cs     out  2  Chip selects, active-low, [0]=chip 1, [1]=chip 2
//  n_wait      out  1  CPU wait request, active-low
//  busy        out  2  Per-chip recovery in progress (debug/status)
// BEHAVIOUR
//  Reset: state IDLE; n_ard=n_awr=1, n_ym_cs=2'b11, n_wait=1, ad_oe=0, d_out_en=0, d_out=8'hFF,
//   ad_out=0, aa0=0, recovery counters=0, busy=0. Reset mid-cycle releases all strobes immediately.
//  States: IDLE -> (RECOV_WAIT) -> SETUP -> STROBE -> HOLD -> DONE -> IDLE.
//  IDLE: on io_req rising (registered edge detect), latch chip_sel, io_wr, io_a0, d_in.
//   Target chip busy -> RECOV_WAIT, else -> SETUP.
//  RECOV_WAIT: wait until target counter reaches 0, then SETUP.
//  SETUP: CS low, aa0 valid; write: ad_oe=1. SETUP_CYC cycles.
//  STROBE: n_awr or n_ard low for STROBE_CYC cycles. Read: ad_in captured into d_out on the last STROBE cycle.
//  HOLD: strobe high, CS/aa0/ad_oe held HOLD_CYC cycles. Write: load target counter with
//   ADDR_RECOV (a0=0) or DATA_RECOV (a0=1) on HOLD entry.
//  DONE: CS released; wait for io_req low, then IDLE. No second cycle per io_req assertion.
//  n_wait: low from the cycle after io_req rise until HOLD entry; high otherwise.
//   Min stretch = SETUP_CYC+STROBE_CYC cycles.
//  d_out_en = io_req & ~io_wr_latched & state in {HOLD, DONE}; d_out retains value until next read.
//  Recovery counters: 5-bit, per chip, decrement to 0 each clkcpu, saturate at 0. busy[i] = cnt[i]!=0.
//   Counters keep running in every state. Accessing the other chip is never delayed.
//  Abort: io_req low before DONE -> next cycle IDLE; strobes/CS/ad_oe/n_wait released.
//   Recovery is loaded if n_awr had been low >=1 cycle.
//  Simultaneous: counter load and decrement in same cycle -> load wins.
// STRUCTURE
//  Shared package tsfm_pkg: state enum, chip index constants, recovery counter width (5).
//  One sub-module: tsfm_recov_cnt (load/decrement/busy), instantiated twice.
//  Counter widths: 2-bit setup/hold, 3-bit strobe, sized from parameter maxima.
// TESTING
//  Write chip 1, a0=0, d=8'h2D: CS[0] low 5 cycles; n_awr low cycles 2-4; ad_out=2D; busy[0] for 2 cycles.
//  Data write a0=1 then immediate second write to chip 1: n_wait held low until 17-cycle recovery ends,
//   then normal cycle.
//  Data write chip 1 then write chip 2 back-to-back: chip 2 cycle starts with no recovery wait.
//  Read chip 2, ad_in=8'hA5: d_out=A5, d_out_en high from HOLD until io_req drops; n_ard low 3 cycles.
//  io_req dropped during STROBE of data write: strobes released next cycle, IDLE, busy[0] set.
//  rst_n low mid-STROBE: all outputs at reset values asynchronously; counters cleared.

Source files
------------

// File: rtl/tsfm_pkg.sv
// Shared types and constants for the TurboSound FM bus-cycle sequencer.
package tsfm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECOV_WAIT,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } tsfm_state_e;

    localparam int CHIP1   = 0;
    localparam int CHIP2   = 1;
    localparam int RECOV_W = 5;

endpackage

// File: rtl/tsfm_recov_cnt.sv
// Per-chip write-recovery counter: load on a finished write, count down to zero.
module tsfm_recov_cnt
    import tsfm_pkg::*;
(
    input  logic               clkcpu,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [RECOV_W-1:0] load_val_i,
    output logic               busy_o
);

    logic [RECOV_W-1:0] cnt_q;
    logic [RECOV_W-1:0] cnt_d;

    // A load in the same cycle as a decrement takes priority.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/tsfm_bus_seq.sv
// Sequences a decoded Z80 I/O access into a timed YM2203 cycle (setup, strobe, hold),
// stretching the CPU with n_wait while the target chip is recovering or the cycle runs.
module tsfm_bus_seq
    import tsfm_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1,
    parameter int ADDR_RECOV = 2,
    parameter int DATA_RECOV = 17
) (
    input  logic       clkcpu,
    input  logic       rst_n,
    input  logic       io_req,
    input  logic       io_wr,
    input  logic       io_a0,
    input  logic       chip_sel,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_out_en,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       aa0,
    output logic       n_ard,
    output logic       n_awr,
    output logic [1:0] n_ym_cs,
    output logic       n_wait,
    output logic [1:0] busy
);

    localparam logic [1:0] SETUP_LAST  = 2'(SETUP_CYC - 1);
    localparam logic [2:0] STROBE_LAST = 3'(STROBE_CYC - 1);
    localparam logic [1:0] HOLD_LAST   = 2'(HOLD_CYC - 1);

    tsfm_state_e state_q;
    logic        req_q;
    logic        chip_q, wr_q, a0_q;
    logic [1:0]  ph_q;
    logic [2:0]  stb_q;
    logic [7:0]  d_out_q, ad_out_q;
    logic        ad_oe_q, aa0_q, n_ard_q, n_awr_q, n_wait_q;
    logic [1:0]  n_cs_q;

    logic               req_rise;
    logic               in_cycle;
    logic               tgt_chip, tgt_wr, tgt_a0;
    logic               wr_load;
    logic [1:0]         load;
    logic [RECOV_W-1:0] load_val;

    assign req_rise = io_req & ~req_q;
    assign in_cycle = (state_q == ST_RECOV_WAIT) || (state_q == ST_SETUP) ||
                      (state_q == ST_STROBE) || (state_q == ST_HOLD);

    // In IDLE the access is being accepted this edge, so use the live inputs.
    assign tgt_chip = (state_q == ST_IDLE) ? chip_sel : chip_q;
    assign tgt_wr   = (state_q == ST_IDLE) ? io_wr    : wr_q;
    assign tgt_a0   = (state_q == ST_IDLE) ? io_a0    : a0_q;

    // Recovery starts on HOLD entry, or on an abort once n_awr has been low.
    assign wr_load  = (state_q == ST_STROBE) && wr_q && (!io_req || (stb_q == STROBE_LAST));
    assign load     = {wr_load & chip_q, wr_load & ~chip_q};
    assign load_val = a0_q ? RECOV_W'(DATA_RECOV) : RECOV_W'(ADDR_RECOV);

    tsfm_recov_cnt u_recov_c1 (
        .clkcpu     (clkcpu),
        .rst_n      (rst_n),
        .load_i     (load[CHIP1]),
        .load_val_i (load_val),
        .busy_o     (busy[CHIP1])
    );

    tsfm_recov_cnt u_recov_c2 (
        .clkcpu     (clkcpu),
        .rst_n      (rst_n),
        .load_i     (load[CHIP2]),
        .load_val_i (load_val),
        .busy_o     (busy[CHIP2])
    );

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            chip_q   <= 1'b0;
            wr_q     <= 1'b0;
            a0_q     <= 1'b0;
            ph_q     <= '0;
            stb_q    <= '0;
            d_out_q  <= 8'hFF;
            ad_out_q <= 8'h00;
            ad_oe_q  <= 1'b0;
            aa0_q    <= 1'b0;
            n_ard_q  <= 1'b1;
            n_awr_q  <= 1'b1;
            n_wait_q <= 1'b1;
            n_cs_q   <= 2'b11;
        end else begin
            req_q <= io_req;
            if (in_cycle && !io_req) begin
                state_q  <= ST_IDLE;
                n_cs_q   <= 2'b11;
                n_ard_q  <= 1'b1;
                n_awr_q  <= 1'b1;
                ad_oe_q  <= 1'b0;
                n_wait_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (req_rise) begin
                            chip_q   <= chip_sel;
                            wr_q     <= io_wr;
                            a0_q     <= io_a0;
                            ad_out_q <= d_in;
                            n_wait_q <= 1'b0;
                            if (busy[tgt_chip]) begin
                                state_q <= ST_RECOV_WAIT;
                            end else begin
                                state_q <= ST_SETUP;
                                ph_q    <= '0;
                                n_cs_q  <= tgt_chip ? 2'b01 : 2'b10;
                                aa0_q   <= tgt_a0;
                                ad_oe_q <= tgt_wr;
                            end
                        end
                    end
                    ST_RECOV_WAIT: begin
                        if (!busy[tgt_chip]) begin
                            state_q <= ST_SETUP;
                            ph_q    <= '0;
                            n_cs_q  <= tgt_chip ? 2'b01 : 2'b10;
                            aa0_q   <= tgt_a0;
                            ad_oe_q <= tgt_wr;
                        end
                    end
                    ST_SETUP: begin
                        if (ph_q == SETUP_LAST) begin
                            state_q <= ST_STROBE;
                            stb_q   <= '0;
                            n_awr_q <= ~wr_q;
                            n_ard_q <= wr_q;
                        end else begin
                            ph_q <= ph_q + 1'b1;
                        end
                    end
                    ST_STROBE: begin
                        if (stb_q == STROBE_LAST) begin
                            state_q  <= ST_HOLD;
                            ph_q     <= '0;
                            n_awr_q  <= 1'b1;
                            n_ard_q  <= 1'b1;
                            n_wait_q <= 1'b1;
                            if (!wr_q) begin
                                d_out_q <= ad_in;
                            end
                        end else begin
                            stb_q <= stb_q + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (ph_q == HOLD_LAST) begin
                            state_q <= ST_DONE;
                            n_cs_q  <= 2'b11;
                            ad_oe_q <= 1'b0;
                        end else begin
                            ph_q <= ph_q + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (!io_req) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign d_out    = d_out_q;
    assign d_out_en = io_req & ~wr_q & ((state_q == ST_HOLD) || (state_q == ST_DONE));
    assign ad_out   = ad_out_q;
    assign ad_oe    = ad_oe_q;
    assign aa0      = aa0_q;
    assign n_ard    = n_ard_q;
    assign n_awr    = n_awr_q;
    assign n_ym_cs  = n_cs_q;
    assign n_wait   = n_wait_q;

endmodule

// File: tb/tb_tsfm_bus_seq.sv
// Bench for tsfm_bus_seq: timed write/read cycles, recovery stalls, abort and async reset.
module tb_tsfm_bus_seq;

  logic       clkcpu;
  logic       rst_n;
  logic       io_req, io_wr, io_a0, chip_sel;
  logic [7:0] d_in, ad_in;
  logic [7:0] d_out, ad_out;
  logic       d_out_en, ad_oe, aa0, n_ard, n_awr, n_wait;
  logic [1:0] n_ym_cs, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  logic [7:0] rd_q[$];

  int r_cs_first, r_cs_n, r_stb_n, r_stb_first, r_wait_first, r_wait_n;
  int r_busy_n, r_busy_pre, r_busy_at_cs, r_oe_n, r_den_n, r_other, r_bad_stb;
  int n_more;

  tsfm_bus_seq dut (
    .clkcpu   (clkcpu),
    .rst_n    (rst_n),
    .io_req   (io_req),
    .io_wr    (io_wr),
    .io_a0    (io_a0),
    .chip_sel (chip_sel),
    .d_in     (d_in),
    .d_out    (d_out),
    .d_out_en (d_out_en),
    .ad_in    (ad_in),
    .ad_out   (ad_out),
    .ad_oe    (ad_oe),
    .aa0      (aa0),
    .n_ard    (n_ard),
    .n_awr    (n_awr),
    .n_ym_cs  (n_ym_cs),
    .n_wait   (n_wait),
    .busy     (busy)
  );

  // clock / reset
  initial begin
    clkcpu = 1'b0;
    forever #5 clkcpu = ~clkcpu;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkcpu);
    #1;
  endtask

  // scoreboard: write data checked when n_awr falls, read data when d_out_en rises
  logic prev_awr = 1'b1;
  logic prev_den = 1'b0;
  always begin
    @(posedge clkcpu);
    #1;
    if (prev_awr && !n_awr) begin
      if (exp_q.size() == 0) check("sb_wr_empty", 1, 0);
      else check("sb_wr_a0_data", {23'd0, aa0, ad_out}, {23'd0, exp_q.pop_front()});
    end
    if (!prev_den && d_out_en) begin
      if (rd_q.size() == 0) check("sb_rd_empty", 1, 0);
      else check("sb_rd_data", {24'd0, d_out}, {24'd0, rd_q.pop_front()});
    end
    prev_awr = n_awr;
    prev_den = d_out_en;
  end

  // driver: one full access, measuring the chip-side waveform
  task automatic run_access(input logic chip, input logic wr, input logic a0, input logic [7:0] data);
    logic done;
    logic stb;
    if (wr) exp_q.push_back({a0, data});
    else rd_q.push_back(ad_in);
    chip_sel = chip; io_wr = wr; io_a0 = a0; d_in = data; io_req = 1'b1;
    r_cs_first = 0; r_cs_n = 0; r_stb_n = 0; r_stb_first = 0; r_wait_first = 0; r_wait_n = 0;
    r_busy_n = 0; r_busy_pre = 0; r_busy_at_cs = 0; r_oe_n = 0; r_den_n = 0; r_other = 0;
    r_bad_stb = 0;
    done = 1'b0;
    for (int k = 1; k <= 100 && !done; k++) begin
      tick();
      if (!n_ym_cs[chip]) begin
        if (r_cs_n == 0) begin
          r_cs_first = k;
          r_busy_at_cs = int'(busy[chip]);
        end
        r_cs_n++;
      end else if (r_cs_n > 0) begin
        done = 1'b1;
      end else if (busy[chip]) begin
        r_busy_pre++;
      end
      if (!(chip ? n_ym_cs[0] : n_ym_cs[1])) r_other++;
      stb = wr ? n_awr : n_ard;
      if (!(wr ? n_ard : n_awr)) r_bad_stb++;
      if (!stb) begin
        if (r_stb_n == 0) r_stb_first = k - r_cs_first + 1;
        r_stb_n++;
      end
      if (!n_wait) begin
        if (r_wait_n == 0) r_wait_first = k;
        r_wait_n++;
      end
      if (busy[chip]) r_busy_n++;
      if (ad_oe) r_oe_n++;
      if (d_out_en) r_den_n++;
    end
    if (!done) check("access_timeout", 0, 1);
    io_req = 1'b0;
    tick();
    if (busy[chip]) r_busy_n++;
    check("den_off_after_req", {31'd0, d_out_en}, 0);
  endtask

  task automatic count_busy(input logic chip, output int n);
    n = 0;
    while (busy[chip] && n < 100) begin
      tick();
      if (busy[chip]) n++;
    end
  endtask

  task automatic check_std(input string tag, input bit wr);
    check({tag, "_cs_first"}, r_cs_first, 1);
    check({tag, "_cs_len"}, r_cs_n, 5);
    check({tag, "_stb_len"}, r_stb_n, 3);
    check({tag, "_stb_pos"}, r_stb_first, 2);
    check({tag, "_wait_first"}, r_wait_first, 1);
    check({tag, "_wait_len"}, r_wait_n, 4);
    check({tag, "_oe_len"}, r_oe_n, wr ? 5 : 0);
    check({tag, "_other_cs"}, r_other, 0);
    check({tag, "_wrong_stb"}, r_bad_stb, 0);
  endtask

  initial begin
    rst_n = 1'b0; io_req = 1'b0; io_wr = 1'b0; io_a0 = 1'b0; chip_sel = 1'b0;
    d_in = 8'h00; ad_in = 8'h00;
    #12;
    check("rst_outs", {d_out, ad_out, ad_oe, aa0, n_ard, n_awr, n_ym_cs, n_wait, d_out_en, busy},
          {8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 2'b00});
    tick();
    rst_n = 1'b1;
    tick(); tick();

    // address write chip 1
    run_access(1'b0, 1'b1, 1'b0, 8'h2D);
    check_std("aw1", 1'b1);
    count_busy(1'b0, n_more);
    check("aw1_busy_len", r_busy_n + n_more, 2);

    // data write chip 1, then immediate second write to chip 1
    run_access(1'b0, 1'b1, 1'b1, 8'h91);
    check_std("dw1", 1'b1);
    run_access(1'b0, 1'b1, 1'b0, 8'h44);
    check("stall_cs_delayed", {31'd0, r_cs_first > 1}, 1);
    check("stall_no_cs_busy", r_busy_at_cs, 0);
    check("stall_not_late", {31'd0, r_cs_first <= r_busy_pre + 2}, 1);
    check("stall_wait_first", r_wait_first, 1);
    check("stall_wait_len", r_wait_n, r_cs_first + 3);
    check("stall_cs_len", r_cs_n, 5);
    check("stall_stb_len", r_stb_n, 3);
    count_busy(1'b0, n_more);

    // data write chip 1 then chip 2 back-to-back: no cross-chip stall
    run_access(1'b0, 1'b1, 1'b1, 8'h3E);
    run_access(1'b1, 1'b1, 1'b0, 8'hC7);
    check_std("xchip", 1'b1);
    check("xchip_c1_still_busy", {31'd0, busy[0]}, 1);
    count_busy(1'b1, n_more);
    check("xchip_c2_busy_len", r_busy_n + n_more, 2);
    count_busy(1'b0, n_more);

    // data write chip 2 alone: full data recovery length
    run_access(1'b1, 1'b1, 1'b1, 8'h5B);
    check_std("dw2", 1'b1);
    count_busy(1'b1, n_more);
    check("dw2_busy_len", r_busy_n + n_more, 17);

    // read chip 2
    ad_in = 8'hA5;
    run_access(1'b1, 1'b0, 1'b0, 8'h00);
    check_std("rd2", 1'b0);
    check("rd2_den_len", r_den_n, 2);
    check("rd2_dout", {24'd0, d_out}, 32'hA5);
    check("rd2_no_busy", {30'd0, busy}, 0);
    ad_in = 8'h11;
    tick();
    check("rd2_dout_hold", {24'd0, d_out}, 32'hA5);

    // abort during strobe of a data write
    exp_q.push_back({1'b1, 8'h77});
    chip_sel = 1'b0; io_wr = 1'b1; io_a0 = 1'b1; d_in = 8'h77; io_req = 1'b1;
    tick(); tick();
    check("abort_in_strobe", {31'd0, n_awr}, 0);
    io_req = 1'b0;
    tick();
    check("abort_released", {n_awr, n_ard, n_ym_cs, n_wait, ad_oe}, {1'b1, 1'b1, 2'b11, 1'b1, 1'b0});
    check("abort_busy", {30'd0, busy}, 32'h1);
    tick();
    check("abort_busy_next", {30'd0, busy}, 32'h1);
    count_busy(1'b0, n_more);

    // async reset mid-strobe with chip 2 recovering
    run_access(1'b1, 1'b1, 1'b1, 8'h66);
    exp_q.push_back({1'b0, 8'h3C});
    chip_sel = 1'b0; io_wr = 1'b1; io_a0 = 1'b0; d_in = 8'h3C; io_req = 1'b1;
    tick(); tick();
    check("rst_pre_strobe", {30'd0, n_awr, busy[1]}, 32'h1);
    #2;
    rst_n = 1'b0;
    io_req = 1'b0;
    #1;
    check("rst_mid_outs", {d_out, ad_out, ad_oe, aa0, n_ard, n_awr, n_ym_cs, n_wait, d_out_en, busy},
          {8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 2'b00});
    tick();
    rst_n = 1'b1;
    tick();

    // normal operation after reset
    run_access(1'b1, 1'b1, 1'b0, 8'h5A);
    check_std("post_rst", 1'b1);
    count_busy(1'b1, n_more);
    check("post_rst_busy_len", r_busy_n + n_more, 2);

    tick();
    check("sb_left", exp_q.size() + rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
